// File: rtl/frame_checker_pkg.sv
// ============================================================================
// Package     : frame_pkg
// Description : Shared definitions for the 64-bit block-stream frame generator
//               and frame checker: control/data codes, payload limits, error
//               code and FSM state enums, lane-extract and saturating-add
//               helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package frame_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int CTRL_WIDTH = DATA_WIDTH / 8;

  localparam logic [7:0] START_CODE     = 8'hFB;
  localparam logic [7:0] PREAMBLE_CODE  = 8'h55;
  localparam logic [7:0] SFD_CODE       = 8'hD5;
  localparam logic [7:0] TERMINATE_CODE = 8'hFD;
  localparam logic [7:0] FCS_CODE       = 8'hC0;

  localparam logic [15:0] DEF_MIN_PAYLOAD = 16'd46;
  localparam logic [15:0] DEF_MAX_PAYLOAD = 16'd1500;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_PREAMBLE = 3'd1,
    ERR_CTRL     = 3'd2,
    ERR_TRUNC    = 3'd3,
    ERR_LEN      = 3'd4,
    ERR_FCS      = 3'd5,
    ERR_RESTART  = 3'd6,
    ERR_ZERO     = 3'd7
  } err_code_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    HDR0 = 3'd2,
    HDR1 = 3'd3,
    PAY  = 3'd4
  } state_t;

  // Lane 0 is the first byte on the wire and sits in the top byte of the bus.
  function automatic logic [7:0] lane(input logic [DATA_WIDTH-1:0] data,
                                      input logic [2:0] k);
    logic [7:0] b;
    b = data[63:56];
    case (k)
      3'd0: b = data[63:56];
      3'd1: b = data[55:48];
      3'd2: b = data[47:40];
      3'd3: b = data[39:32];
      3'd4: b = data[31:24];
      3'd5: b = data[23:16];
      3'd6: b = data[15:8];
      3'd7: b = data[7:0];
      default: b = data[63:56];
    endcase
    return b;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                            input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_checker_if.sv
// ============================================================================
// Interface   : frame_checker_if
// Description : Receive block stream into the frame checker and the per-frame
//               result/statistics bus coming back out of it.
//               master : drives i_rx_data / i_rx_ctrl, observes results.
//               slave  : the checker.
//               o_drop_count exists only with FRAME_CHECKER_DST_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface frame_checker_if;
  import frame_pkg::*;

  logic [DATA_WIDTH-1:0] i_rx_data;
  logic [CTRL_WIDTH-1:0] i_rx_ctrl;
  logic                  o_frame_valid;
  logic                  o_frame_error;
  logic [2:0]            o_err_code;
  logic [47:0]           o_dst_addr;
  logic [47:0]           o_src_addr;
  logic [15:0]           o_len_typ;
  logic [15:0]           o_payload_len;
  logic [15:0]           o_frame_count;
  logic [15:0]           o_error_count;
`ifdef FRAME_CHECKER_DST_FILTER_EN
  logic [15:0]           o_drop_count;
`endif

  modport master (
    output i_rx_data, i_rx_ctrl,
    input  o_frame_valid, o_frame_error, o_err_code, o_dst_addr, o_src_addr,
           o_len_typ, o_payload_len, o_frame_count, o_error_count
`ifdef FRAME_CHECKER_DST_FILTER_EN
    , input o_drop_count
`endif
  );

  modport slave (
    input  i_rx_data, i_rx_ctrl,
    output o_frame_valid, o_frame_error, o_err_code, o_dst_addr, o_src_addr,
           o_len_typ, o_payload_len, o_frame_count, o_error_count
`ifdef FRAME_CHECKER_DST_FILTER_EN
    , output o_drop_count
`endif
  );

endinterface

`default_nettype wire

// File: rtl/frame_checker_stats.sv
// ============================================================================
// Module      : frame_checker_stats
// Description : Saturating 16-bit good/error (and optionally drop) frame
//               counters. Fed with next-cycle pulse values so each count
//               changes in the same cycle its pulse becomes visible.
// Ports       : clk, i_rst (sync, active-high)
//               i_pass / i_err / i_drop - increment requests
//               o_frame_count / o_error_count / o_drop_count - counter values
// Macro       : FRAME_CHECKER_DST_FILTER_EN adds i_drop / o_drop_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_checker_stats
  import frame_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        i_rst,
  input  wire logic        i_pass,
  input  wire logic        i_err,
`ifdef FRAME_CHECKER_DST_FILTER_EN
  input  wire logic        i_drop,
  output logic [15:0]      o_drop_count,
`endif
  output logic [15:0]      o_frame_count,
  output logic [15:0]      o_error_count
);

  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] error_cnt_q, error_cnt_d;
`ifdef FRAME_CHECKER_DST_FILTER_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
`endif

  always_comb begin
    frame_cnt_d = i_pass ? sat_add16(frame_cnt_q, 16'd1) : frame_cnt_q;
    error_cnt_d = i_err  ? sat_add16(error_cnt_q, 16'd1) : error_cnt_q;
`ifdef FRAME_CHECKER_DST_FILTER_EN
    drop_cnt_d  = i_drop ? sat_add16(drop_cnt_q, 16'd1)  : drop_cnt_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      frame_cnt_q <= '0;
      error_cnt_q <= '0;
`ifdef FRAME_CHECKER_DST_FILTER_EN
      drop_cnt_q  <= '0;
`endif
    end else begin
      frame_cnt_q <= frame_cnt_d;
      error_cnt_q <= error_cnt_d;
`ifdef FRAME_CHECKER_DST_FILTER_EN
      drop_cnt_q  <= drop_cnt_d;
`endif
    end
  end

  assign o_frame_count = frame_cnt_q;
  assign o_error_count = error_cnt_q;
`ifdef FRAME_CHECKER_DST_FILTER_EN
  assign o_drop_count  = drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: rtl/frame_checker.sv
// ============================================================================
// Module      : frame_checker
// Description : Receive-side parser for the 64-bit block stream (start,
//               preamble/SFD, two header blocks, payload, FCS, terminate).
//               Emits a one-cycle pass or error pulse per frame with error
//               code, captured header fields and payload length, and keeps
//               saturating statistics.
// Ports       : clk, i_rst (sync, active-high)
//               bus (frame_checker_if.slave): i_rx_data/i_rx_ctrl in;
//               o_frame_valid, o_frame_error, o_err_code, o_dst_addr,
//               o_src_addr, o_len_typ, o_payload_len, o_frame_count,
//               o_error_count [, o_drop_count] out.
// Macro       : FRAME_CHECKER_DST_FILTER_EN - drop otherwise-good frames
//               whose destination differs from FILTER_DST_ADDR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_checker
  import frame_pkg::*;
#(
  parameter logic [15:0] MIN_PAYLOAD = DEF_MIN_PAYLOAD,
  parameter logic [15:0] MAX_PAYLOAD = DEF_MAX_PAYLOAD
`ifdef FRAME_CHECKER_DST_FILTER_EN
  ,
  parameter logic [47:0] FILTER_DST_ADDR = 48'h0180C2000001
`endif
) (
  input  wire logic      clk,
  input  wire logic      i_rst,
  frame_checker_if.slave bus
);

  logic [DATA_WIDTH-1:0] rx_data;
  logic [CTRL_WIDTH-1:0] rx_ctrl;
  logic                  is_start;
  logic                  is_term;
  logic                  pre_ok;

  assign rx_data  = bus.i_rx_data;
  assign rx_ctrl  = bus.i_rx_ctrl;
  assign is_start = rx_ctrl[0] && (lane(rx_data, 3'd0) == START_CODE);
  assign is_term  = rx_ctrl[0] && (lane(rx_data, 3'd0) == TERMINATE_CODE);
  assign pre_ok   = (rx_ctrl == '0) &&
                    (rx_data[63:16] == {6{PREAMBLE_CODE}}) &&
                    (lane(rx_data, 3'd6) == SFD_CODE);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  // Only lanes 4-7 of the held block are ever inspected (FCS bytes).
  logic [31:0] held_q, held_d;
  logic        held_v_q, held_v_d;
  logic        zero_q, zero_d;
  logic [47:0] dst_q, dst_d;
  logic [47:0] src_q, src_d;
  logic [15:0] lt_q, lt_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  err_code_t   code_q, code_d;
  logic [47:0] dst_out_q, dst_out_d;
  logic [47:0] src_out_q, src_out_d;
  logic [15:0] lt_out_q, lt_out_d;
  logic [15:0] plen_q, plen_d;
  logic        drop_d;

  logic        dec;
  err_code_t   dec_code;
  logic [15:0] dec_len;
  logic [15:0] term_cnt;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    held_d    = held_q;
    held_v_d  = held_v_q;
    zero_d    = zero_q;
    dst_d     = dst_q;
    src_d     = src_q;
    lt_d      = lt_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    drop_d    = 1'b0;
    code_d    = ERR_NONE;
    dst_out_d = dst_out_q;
    src_out_d = src_out_q;
    lt_out_d  = lt_out_q;
    plen_d    = plen_q;
    dec       = 1'b0;
    dec_code  = ERR_NONE;
    dec_len   = cnt_q;
    term_cnt  = sat_add16(cnt_q, 16'd4);

    case (state_q)
      IDLE: begin
        if (is_start) state_d = PRE;
      end
      PRE: begin
        state_d = HDR0;
        if (!pre_ok) begin
          dec      = 1'b1;
          dec_code = ERR_PREAMBLE;
        end
      end
      HDR0: begin
        state_d = HDR1;
        dst_d   = rx_data[63:16];
        src_d   = {rx_data[15:0], src_q[31:0]};
        if (rx_ctrl != '0) begin
          dec      = 1'b1;
          dec_code = ERR_CTRL;
        end
      end
      HDR1: begin
        state_d  = PAY;
        src_d    = {src_q[47:32], rx_data[63:32]};
        lt_d     = rx_data[31:16];
        cnt_d    = 16'd2;   // lanes 6-7 already carry payload
        held_v_d = 1'b0;
        zero_d   = 1'b0;
        if (rx_ctrl != '0) begin
          dec      = 1'b1;
          dec_code = ERR_CTRL;
        end
      end
      PAY: begin
        if (rx_ctrl == '0) begin
          // A block is counted only once a later block proves it is not
          // the final payload+FCS block.
          if (held_v_q) cnt_d = sat_add16(cnt_q, 16'd8);
          held_d   = rx_data[31:0];
          held_v_d = 1'b1;
          if (rx_data == '0) zero_d = 1'b1;
        end else if (is_term) begin
          dec     = 1'b1;
          dec_len = term_cnt;
          if (!held_v_q || (term_cnt < MIN_PAYLOAD) || (term_cnt > MAX_PAYLOAD))
            dec_code = ERR_LEN;
          else if (held_q != {4{FCS_CODE}})
            dec_code = ERR_FCS;
          else if (zero_q)
            dec_code = ERR_ZERO;
          else
            dec_code = ERR_NONE;
        end else if (is_start) begin
          dec      = 1'b1;
          dec_code = ERR_RESTART;
        end else if (rx_ctrl == '1) begin
          dec      = 1'b1;
          dec_code = ERR_TRUNC;
        end else begin
          dec      = 1'b1;
          dec_code = ERR_CTRL;
        end
      end
      default: state_d = IDLE;
    endcase

    if (dec) begin
      dst_out_d = dst_d;
      src_out_d = src_d;
      lt_out_d  = lt_d;
      plen_d    = dec_len;
      if (dec_code != ERR_NONE) begin
        error_d = 1'b1;
        code_d  = dec_code;
        // The start block that aborted the frame also opens the next one.
        state_d = (dec_code == ERR_RESTART) ? PRE : IDLE;
      end else begin
        state_d = IDLE;
`ifdef FRAME_CHECKER_DST_FILTER_EN
        if (dst_q != FILTER_DST_ADDR) drop_d  = 1'b1;
        else                          valid_d = 1'b1;
`else
        valid_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      held_q    <= '0;
      held_v_q  <= 1'b0;
      zero_q    <= 1'b0;
      dst_q     <= '0;
      src_q     <= '0;
      lt_q      <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      code_q    <= ERR_NONE;
      dst_out_q <= '0;
      src_out_q <= '0;
      lt_out_q  <= '0;
      plen_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      held_q    <= held_d;
      held_v_q  <= held_v_d;
      zero_q    <= zero_d;
      dst_q     <= dst_d;
      src_q     <= src_d;
      lt_q      <= lt_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      code_q    <= code_d;
      dst_out_q <= dst_out_d;
      src_out_q <= src_out_d;
      lt_out_q  <= lt_out_d;
      plen_q    <= plen_d;
    end
  end

  assign bus.o_frame_valid = valid_q;
  assign bus.o_frame_error = error_q;
  assign bus.o_err_code    = code_q;
  assign bus.o_dst_addr    = dst_out_q;
  assign bus.o_src_addr    = src_out_q;
  assign bus.o_len_typ     = lt_out_q;
  assign bus.o_payload_len = plen_q;

  frame_checker_stats u_stats (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_pass        (valid_d),
    .i_err         (error_d),
`ifdef FRAME_CHECKER_DST_FILTER_EN
    .i_drop        (drop_d),
    .o_drop_count  (bus.o_drop_count),
`endif
    .o_frame_count (bus.o_frame_count),
    .o_error_count (bus.o_error_count)
  );

endmodule

`default_nettype wire
